// File: rtl/dual_grant_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// dual_grant_scheduler_pkg
// Shared constants and types for the dual-slot rotating-priority scheduler.
//   N_REQ     : default number of requesters
//   IDX_W     : default width of a requester index
//   PTR_RESET : pointer value after reset (plain MSB-first priority)
//   slot_state_e : per-slot ownership state
// -----------------------------------------------------------------------------
package dual_grant_scheduler_pkg;

    localparam int N_REQ     = 12;
    localparam int IDX_W     = 4;
    localparam int PTR_RESET = N_REQ - 1;

    typedef enum logic {
        SLOT_IDLE = 1'b0,
        SLOT_BUSY = 1'b1
    } slot_state_e;

endpackage

// File: rtl/dual_grant_scheduler_if.sv
// -----------------------------------------------------------------------------
// dual_grant_scheduler_if
// Bundles the request/done inputs and the grant/ownership outputs of the
// scheduler.
//   master : requester side (drives req, done0, done1; observes the rest)
//   slave  : scheduler side (observes req/done; drives grant and status)
// -----------------------------------------------------------------------------
interface dual_grant_scheduler_if
    import dual_grant_scheduler_pkg::*;
#(
    parameter int N   = N_REQ,
    parameter int IDW = IDX_W
) ();

    logic [N-1:0]   req;
    logic           done0;
    logic           done1;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] first;
    logic           first_valid;
    logic [IDW-1:0] second;
    logic           second_valid;
    logic           busy0;
    logic           busy1;
    logic [IDW-1:0] owner0;
    logic [IDW-1:0] owner1;
    logic [IDW-1:0] ptr;

    modport master (
        output req, done0, done1,
        input  gnt, first, first_valid, second, second_valid,
        input  busy0, busy1, owner0, owner1, ptr
    );

    modport slave (
        input  req, done0, done1,
        output gnt, first, first_valid, second, second_valid,
        output busy0, busy1, owner0, owner1, ptr
    );

endinterface

// File: rtl/dual_grant_scheduler_rot_dual_prienc.sv
// -----------------------------------------------------------------------------
// rot_dual_prienc
// Combinational rotating dual priority encoder. Finds the first and second set
// bits of elig_i searching ptr_i, ptr_i-1, ..., 0, N-1, ..., ptr_i+1.
//   elig_i     : eligible requesters
//   ptr_i      : highest-priority index (must be < N)
//   c1_o/c1_valid_o : first eligible index in search order
//   c2_o/c2_valid_o : second eligible index in search order
// With ptr_i = N-1 it degenerates to a plain MSB-first dual priority encoder.
// -----------------------------------------------------------------------------
module rot_dual_prienc
    import dual_grant_scheduler_pkg::*;
#(
    parameter int N   = N_REQ,
    parameter int IDW = IDX_W
) (
    input  logic [N-1:0]   elig_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [IDW-1:0] c1_o,
    output logic           c1_valid_o,
    output logic [IDW-1:0] c2_o,
    output logic           c2_valid_o
);

    logic [N-1:0]   rot;
    logic [IDW-1:0] pos1;
    logic [IDW-1:0] pos2;
    logic           v1;
    logic           v2;

    // Index arithmetic modulo N; inputs lie in (-N, N).
    function automatic logic [IDW-1:0] wrap_idx(input int v);
        int w;
        w = (v < 0) ? v + N : v;
        return IDW'(w);
    endfunction

    // Rotate so that ptr_i lands on the MSB; search order becomes MSB-first.
    always_comb begin
        rot = '0;
        for (int k = 0; k < N; k++) begin
            rot[N-1-k] = elig_i[wrap_idx(int'(ptr_i) - k)];
        end
    end

    // MSB-first dual priority encode on the rotated vector.
    always_comb begin
        v1   = 1'b0;
        v2   = 1'b0;
        pos1 = '0;
        pos2 = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                if (!v1) begin
                    v1   = 1'b1;
                    pos1 = IDW'(i);
                end else if (!v2) begin
                    v2   = 1'b1;
                    pos2 = IDW'(i);
                end
            end
        end
    end

    // Un-rotate: rotated position p sits N-1-p steps below ptr_i.
    always_comb begin
        c1_o       = wrap_idx(int'(ptr_i) - (N - 1 - int'(pos1)));
        c2_o       = wrap_idx(int'(ptr_i) - (N - 1 - int'(pos2)));
        c1_valid_o = v1;
        c2_valid_o = v2;
    end

endmodule

// File: rtl/dual_grant_scheduler.sv
// -----------------------------------------------------------------------------
// dual_grant_scheduler
// Shares two identical service slots among N requesters using rotating-priority
// dual selection. Grants are registered one-cycle pulses; each slot stays owned
// until its done pulse.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   bus_if : slave side of dual_grant_scheduler_if
//            in : req, done0, done1
//            out: gnt, first/first_valid, second/second_valid,
//                 busy0, busy1, owner0, owner1, ptr
// -----------------------------------------------------------------------------
module dual_grant_scheduler
    import dual_grant_scheduler_pkg::*;
#(
    parameter int N   = N_REQ,
    parameter int IDW = IDX_W
) (
    input  logic                        clk,
    input  logic                        rst,
    dual_grant_scheduler_if.slave       bus_if
);

    localparam logic [IDW-1:0] PTR_RST = IDW'(N - 1);

    slot_state_e    slot0_q, slot0_d;
    slot_state_e    slot1_q, slot1_d;
    logic [IDW-1:0] owner0_q, owner0_d;
    logic [IDW-1:0] owner1_q, owner1_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] first_q, first_d;
    logic [IDW-1:0] second_q, second_d;
    logic           first_valid_q, first_valid_d;
    logic           second_valid_q, second_valid_d;

    logic           busy0, busy1;
    logic [N-1:0]   owned;
    logic [N-1:0]   elig;
    logic [IDW-1:0] c1, c2;
    logic           c1_v, c2_v;
    logic           grant0, grant1;
    logic [IDW-1:0] slot1_idx;
    logic [IDW-1:0] last_idx;

    assign busy0 = (slot0_q == SLOT_BUSY);
    assign busy1 = (slot1_q == SLOT_BUSY);

    // Current owners are masked out so nobody can hold both slots.
    always_comb begin
        owned = '0;
        if (busy0) owned[owner0_q] = 1'b1;
        if (busy1) owned[owner1_q] = 1'b1;
        elig = bus_if.req & ~owned;
    end

    rot_dual_prienc #(
        .N   (N),
        .IDW (IDW)
    ) u_prienc (
        .elig_i     (elig),
        .ptr_i      (ptr_q),
        .c1_o       (c1),
        .c1_valid_o (c1_v),
        .c2_o       (c2),
        .c2_valid_o (c2_v)
    );

    // Slot assignment: the lone idle slot always takes c1; c2 is used only
    // when both slots are idle. last_idx becomes the new lowest priority.
    always_comb begin
        grant0    = 1'b0;
        grant1    = 1'b0;
        slot1_idx = c1;
        last_idx  = c1;
        if (!busy0 && !busy1) begin
            grant0    = c1_v;
            grant1    = c2_v;
            slot1_idx = c2;
            last_idx  = c2_v ? c2 : c1;
        end else if (!busy0) begin
            grant0 = c1_v;
        end else if (!busy1) begin
            grant1 = c1_v;
        end
    end

    // Next state. A done frees the slot from the next cycle; a slot that is
    // busy this cycle is never granted, so no same-edge reuse can happen.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (grant0)               slot0_d = SLOT_BUSY;
        else if (busy0 && bus_if.done0) slot0_d = SLOT_IDLE;
        if (grant1)               slot1_d = SLOT_BUSY;
        else if (busy1 && bus_if.done1) slot1_d = SLOT_IDLE;

        owner0_d = grant0 ? c1 : owner0_q;
        owner1_d = grant1 ? slot1_idx : owner1_q;

        gnt_d = '0;
        if (grant0) gnt_d[c1]        = 1'b1;
        if (grant1) gnt_d[slot1_idx] = 1'b1;

        first_valid_d  = grant0;
        first_d        = grant0 ? c1 : '0;
        second_valid_d = grant1;
        second_d       = grant1 ? slot1_idx : '0;

        ptr_d = ptr_q;
        if (grant0 || grant1) begin
            ptr_d = (last_idx == '0) ? PTR_RST : last_idx - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0_q        <= SLOT_IDLE;
            slot1_q        <= SLOT_IDLE;
            owner0_q       <= '0;
            owner1_q       <= '0;
            ptr_q          <= PTR_RST;
            gnt_q          <= '0;
            first_q        <= '0;
            second_q       <= '0;
            first_valid_q  <= 1'b0;
            second_valid_q <= 1'b0;
        end else begin
            slot0_q        <= slot0_d;
            slot1_q        <= slot1_d;
            owner0_q       <= owner0_d;
            owner1_q       <= owner1_d;
            ptr_q          <= ptr_d;
            gnt_q          <= gnt_d;
            first_q        <= first_d;
            second_q       <= second_d;
            first_valid_q  <= first_valid_d;
            second_valid_q <= second_valid_d;
        end
    end

    assign bus_if.gnt          = gnt_q;
    assign bus_if.first        = first_q;
    assign bus_if.first_valid  = first_valid_q;
    assign bus_if.second       = second_q;
    assign bus_if.second_valid = second_valid_q;
    assign bus_if.busy0        = busy0;
    assign bus_if.busy1        = busy1;
    assign bus_if.owner0       = owner0_q;
    assign bus_if.owner1       = owner1_q;
    assign bus_if.ptr          = ptr_q;

endmodule

// File: tb/tb_dual_grant_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dual_grant_scheduler
// Scoreboard bench: the stimulus process runs a queue-based reference model of
// the scheduler and pushes each expected grant; a negedge monitor pops and
// compares whenever the DUT shows a grant.
// -----------------------------------------------------------------------------
module tb_dual_grant_scheduler;
    import dual_grant_scheduler_pkg::*;

    localparam int N   = N_REQ;
    localparam int IDW = IDX_W;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dual_grant_scheduler_if #(.N(N), .IDW(IDW)) bus ();

    dual_grant_scheduler #(.N(N), .IDW(IDW)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
    );

    typedef struct {
        int           cyc;
        logic [N-1:0] gnt;
        logic         fv;
        int           f;
        logic         sv;
        int           s;
    } exp_t;

    exp_t sbq[$];

    // Reference model state
    bit m_busy[2];
    int m_owner[2];
    int m_ptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy[0] = 0; m_busy[1] = 0;
        m_owner[0] = 0; m_owner[1] = 0;
        m_ptr = N - 1;
        sbq.delete();
    endtask

    // Applies the scheduler rules to the inputs presented for the coming edge.
    task automatic model_step(input logic [N-1:0] req, input bit d0, input bit d1);
        int   order[$];
        int   used;
        int   idx;
        bit   nb[2];
        exp_t e;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr - k + N) % N;
            if (req[idx] && !(m_busy[0] && m_owner[0] == idx) && !(m_busy[1] && m_owner[1] == idx))
                order.push_back(idx);
        end
        nb[0] = m_busy[0] && !d0;
        nb[1] = m_busy[1] && !d1;
        e.cyc = cyc + 1; e.gnt = '0; e.fv = 0; e.f = 0; e.sv = 0; e.s = 0;
        used = 0;
        if (!m_busy[0] && order.size() > used) begin
            e.fv = 1; e.f = order[used]; e.gnt[order[used]] = 1'b1;
            nb[0] = 1; m_owner[0] = order[used]; used++;
        end
        if (!m_busy[1] && order.size() > used) begin
            e.sv = 1; e.s = order[used]; e.gnt[order[used]] = 1'b1;
            nb[1] = 1; m_owner[1] = order[used]; used++;
        end
        if (used > 0) begin
            m_ptr = (order[used-1] - 1 + N) % N;
            sbq.push_back(e);
        end
        m_busy[0] = nb[0];
        m_busy[1] = nb[1];
    endtask

    // One clock: drive inputs, advance model, then check state after the edge.
    task automatic step(input logic [N-1:0] req, input bit d0, input bit d1);
        bus.req = req; bus.done0 = d0; bus.done1 = d1;
        model_step(req, d0, d1);
        @(posedge clk);
        #1;
        chk("busy0", 32'(bus.busy0), 32'(m_busy[0]));
        chk("busy1", 32'(bus.busy1), 32'(m_busy[1]));
        chk("ptr", 32'(bus.ptr), m_ptr);
        if (m_busy[0]) chk("owner0", 32'(bus.owner0), m_owner[0]);
        if (m_busy[1]) chk("owner1", 32'(bus.owner1), m_owner[1]);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"}, 32'(bus.gnt), 0);
        chk({tag, "_fv"}, 32'(bus.first_valid), 0);
        chk({tag, "_sv"}, 32'(bus.second_valid), 0);
        chk({tag, "_first"}, 32'(bus.first), 0);
        chk({tag, "_second"}, 32'(bus.second), 0);
        chk({tag, "_busy"}, {30'd0, bus.busy1, bus.busy0}, 0);
        chk({tag, "_owners"}, {24'd0, bus.owner1, bus.owner0}, 0);
        chk({tag, "_ptr"}, 32'(bus.ptr), N - 1);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.gnt != '0 || bus.first_valid || bus.second_valid) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_grant: got gnt=%b expected no grant (cycle %0d)", bus.gnt, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_cycle", cyc, e.cyc);
                    chk("sb_gnt", 32'(bus.gnt), 32'(e.gnt));
                    chk("sb_fv", 32'(bus.first_valid), 32'(e.fv));
                    chk("sb_sv", 32'(bus.second_valid), 32'(e.sv));
                    if (e.fv) chk("sb_first", 32'(bus.first), e.f);
                    if (e.sv) chk("sb_second", 32'(bus.second), e.s);
                end
            end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                e = sbq.pop_front();
                checks++; errors++;
                $display("FAIL missed_grant: got gnt=0 expected gnt=%b (cycle %0d)", e.gnt, e.cyc);
            end
        end
    end

    initial begin
        logic [N-1:0] req;
        int cnt[N];

        // Reset with the first test-plan request pattern applied
        req = 12'b001001000011;
        bus.req = req; bus.done0 = 1'b0; bus.done1 = 1'b0;
        rst = 1'b1;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        step(req, 0, 0);
        chk("tp1_gnt", 32'(bus.gnt), 32'(12'b001001000000));
        chk("tp1_first", 32'(bus.first), 9);
        chk("tp1_second", 32'(bus.second), 6);
        chk("tp1_valids", {30'd0, bus.first_valid, bus.second_valid}, 3);
        chk("tp1_ptr", 32'(bus.ptr), 5);

        for (int i = 0; i < 5; i++) begin
            step(req, 0, 0);
            chk("hold_gnt", 32'(bus.gnt), 0);
        end
        chk("hold_owners", {24'd0, bus.owner0, bus.owner1}, {24'd0, 4'd9, 4'd6});

        // Free slot0 only
        step(req, 1, 0);
        step(req, 0, 0);
        chk("tp3_gnt", 32'(bus.gnt), 32'(12'b000000000010));
        chk("tp3_first", 32'(bus.first), 1);
        chk("tp3_sv", 32'(bus.second_valid), 0);
        chk("tp3_ptr", 32'(bus.ptr), 0);

        // Simultaneous done on both slots
        req = 12'b111111000001;
        step(req, 1, 1);
        step(req, 0, 0);
        chk("tp4_gnt", 32'(bus.gnt), 32'(12'b100000000001));
        chk("tp4_first", 32'(bus.first), 0);
        chk("tp4_second", 32'(bus.second), 11);
        chk("tp4_ptr", 32'(bus.ptr), 10);

        // Fairness: every index once in six grant cycles
        req = '1;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int r = 0; r < 6; r++) begin
            step(req, 1, 1);
            step(req, 0, 0);
            for (int i = 0; i < N; i++) if (bus.gnt[i]) cnt[i]++;
        end
        for (int i = 0; i < N; i++) chk($sformatf("fair_cnt%0d", i), cnt[i], 1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            req = N'($urandom_range(0, (1 << N) - 1));
            step(req, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end

        // Reset with both slots busy and a grant pulse on the outputs
        step('0, 1, 1);
        step('0, 1, 1);
        step('1, 0, 0);
        chk("pre_rst_busy", {30'd0, bus.busy1, bus.busy0}, 3);
        rst = 1'b1;
        model_reset();
        #1;
        check_reset_outputs("midrst");
        req = 12'b101100000110;
        bus.req = req; bus.done0 = 1'b0; bus.done1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        step(req, 0, 0);
        chk("tp6_first", 32'(bus.first), 11);
        chk("tp6_second", 32'(bus.second), 9);

        // Drain and confirm every expected grant was seen
        step('0, 0, 0);
        step('0, 0, 0);
        chk("sb_empty", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dual_grant_scheduler.md
Name: dual_grant_scheduler

Overview:
- Shares two identical service slots (slot0, slot1) among 12 requesters.
- Uses rotating-priority dual selection: each cycle it picks the first and second eligible requesters, searching downward with wrap-around from a pointer.
- Issues registered grant pulses and tracks slot ownership until each slot's done.
- Sits in front of the shared resource pair that the dual priority encoder feeds.

Parameters:
- N, 12, number of requesters; legal range 2..16.
- IDW, 4, width of requester index; must satisfy 2^IDW >= N.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  N  level request per requester; held high until granted.
- done0  in  1  slot0 finished; single-cycle pulse, meaningful only while busy0=1.
- done1  in  1  slot1 finished; single-cycle pulse, meaningful only while busy1=1.
- gnt  out  N  registered grant pulses; at most 2 bits set.
- first  out  IDW  index granted to slot0 this cycle.
- first_valid  out  1  first is valid.
- second  out  IDW  index granted to slot1 this cycle.
- second_valid  out  1  second is valid.
- busy0  out  1  slot0 owned.
- busy1  out  1  slot1 owned.
- owner0  out  IDW  current slot0 owner.
- owner1  out  IDW  current slot1 owner.
- ptr  out  IDW  current highest-priority index.

Behaviour:
- Reset (async, immediate):
  - gnt=0, first=0, second=0, first_valid=0, second_valid=0.
  - busy0=0, busy1=0, owner0=0, owner1=0.
  - ptr=N-1, i.e. plain MSB-first priority.
- Per-slot FSM, two states:
  - IDLE -> BUSY on a grant edge.
  - BUSY -> IDLE on the edge where done_k=1.
  - done_k in IDLE is ignored.
- Eligible vector: elig = req with bits owner0 (if busy0) and owner1 (if busy1) cleared.
- Search order: ptr, ptr-1, ..., 0, N-1, ..., ptr+1.
  - c1 = first eligible index in that order.
  - c2 = second eligible index in that order.
- Slot assignment:
  - Both slots IDLE: slot0 takes c1, slot1 takes c2 (if c2 exists).
  - Exactly one slot IDLE: that slot takes c1; report it on first/first_valid if slot0, second/second_valid if slot1.
  - No slot IDLE: no grant.
- Latency: decision is combinational on the current req/state and registered at the edge.
  - On that edge: busy_k=1, owner_k=index.
  - gnt bit and first/second (+valid) are asserted for exactly the following cycle.
  - gnt=0 in every other cycle.
- Pointer update when at least one grant occurs: ptr <= (g-1) mod N, where g is the last index granted in search order (c2 if two grants, else c1). Index g therefore becomes lowest priority. ptr is otherwise unchanged.
- A slot freed by done_k is IDLE from the next cycle; no same-edge reuse. The freed owner is eligible again in that next cycle.
- Simultaneous done0 and done1: both slots free next cycle.
- A requester dropping req while owning a slot has no effect on the slot; only done frees it.
- A requester can never own both slots.
- Mid-operation reset: all ownership is lost, no residual grant pulses; req still high after reset is re-arbitrated from ptr=N-1.

Decomposition:
- Shared package holds:
  - Constants N_REQ=12, IDX_W=4, PTR_RESET=N_REQ-1.
  - Slot-state enum {SLOT_IDLE, SLOT_BUSY}.
- One natural sub-module: rot_dual_prienc. It is combinational and computes c1/c2 plus their valid bits from (elig, ptr) by rotating, dual priority encoding, then un-rotating. It is reusable and separately testable against the existing dual priority encoder with ptr=N-1.

Test Plan:
- Reset with req=12'b001001000011, then release:
  - next cycle: gnt=12'b001001000000, first=9, second=6, both valid, busy0=busy1=1, ptr=5.
- Same req held, no done for 5 cycles:
  - gnt=0 throughout, owners stay 9 and 6.
- Pulse done0:
  - one cycle later slot0 IDLE; elig=12'b001000000011.
  - next cycle first=1, gnt=12'b000000000010, second_valid=0, ptr=0.
- Both slots busy (owners 1 and 6), req=12'b111111000001, pulse done0 and done1 together:
  - after the free cycle, search from ptr=0 gives c1=0, c2=11.
  - first=0, second=11, gnt=12'b100000000001, ptr=10.
- Fairness: all 12 req high, done0/done1 pulsed every cycle after each grant:
  - every index is granted exactly once within 6 grant cycles.
  - no index is granted twice before all 12 have been granted.
- Assert rst for 1 cycle while both slots busy with gnt pulse pending:
  - all outputs 0 immediately, ptr=11.
  - with req=12'b101100000110 after release: first=11, second=9.
